// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch->decode queue: widths, nop filler values and predictor bundle layout.
// The packed bundle struct fixes the field offsets that fetch packs and decode unpacks.
package fetch_queue_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH    = 32;
  localparam int GHR_WIDTH   = 8;

  // Bit offsets of the predictor training bundle, LSB first
  localparam int META_TRAIN_VALID    = 0;
  localparam int META_TRAIN_PREDICT  = 1;
  localparam int META_GHR_LSB        = 2;
  localparam int META_GLOBAL_PREDICT = META_GHR_LSB + GHR_WIDTH;
  localparam int META_LOCAL_PREDICT  = META_GLOBAL_PREDICT + 1;
  localparam int META_SUCCESS_HIT    = META_LOCAL_PREDICT + 1;
  localparam int META_JAL            = META_SUCCESS_HIT + 1;
  localparam int FQ_META_WIDTH       = META_JAL + 1;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [PC_WIDTH-1:0]    NOP_PC     = '0;
  localparam logic [PC_WIDTH-1:0]    NOP_NPC    = '0;
  localparam logic                   NOP_COMMIT = 1'b0;

  // Declared MSB first so each field lands on the offsets above
  typedef struct packed {
    logic                 jal;
    logic                 success_hit;
    logic                 local_predict;
    logic                 global_predict;
    logic [GHR_WIDTH-1:0] global_history;
    logic                 train_predict;
    logic                 train_valid;
  } fq_meta_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Read/write pointer pair for the fetch queue: wrap-bit pointers, full/empty and occupancy.
module fetch_queue_ptr
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   rd_ptr,
  output logic [$clog2(DEPTH):0]   wr_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit, so they roll over modulo 2*DEPTH
  always_ff @(posedge clk_i) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Fetch->decode circular buffer; redirect flushes all entries.
// Define FETCH_QUEUE_PERF_EN to add saturating full-stall and flush cycle counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int META_W  = FQ_META_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH,
  parameter int PC_W    = PC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    F_valid_i,
  output logic                    F_ready_o,
  input  logic [INSTR_W-1:0]      F_instr_i,
  input  logic [PC_W-1:0]         F_PC_i,
  input  logic [PC_W-1:0]         F_nPC_i,
  input  logic                    F_commit_i,
  input  logic [META_W-1:0]       F_meta_i,
  input  logic                    decode_allow_in_i,
  output logic                    fetch_vaild_o,
  output logic [INSTR_W-1:0]      FD_instr_o,
  output logic [PC_W-1:0]         FD_PC_o,
  output logic [PC_W-1:0]         FD_nPC_o,
  output logic                    FD_commit_o,
  output logic [META_W-1:0]       FD_meta_o,
  output logic [$clog2(DEPTH):0]  fq_count_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]             fq_full_stall_o,
  output logic [31:0]             fq_flush_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_instr  [DEPTH];
  logic [PC_W-1:0]    mem_pc     [DEPTH];
  logic [PC_W-1:0]    mem_npc    [DEPTH];
  logic               mem_commit [DEPTH];
  logic [META_W-1:0]  mem_meta   [DEPTH];

  logic [AW:0] rd_ptr, wr_ptr;
  logic        full, empty, push, pop, wr_en;

  // Ready looks only at full, so decode never reaches back into fetch combinationally
  assign F_ready_o     = !full;
  assign fetch_vaild_o = !empty;
  assign push          = F_valid_i && F_ready_o;
  assign pop           = fetch_vaild_o && decode_allow_in_i;
  assign wr_en         = push && !flush_i && !rst;

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk_i  (clk_i),
    .rst    (rst),
    .clr    (flush_i),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (fq_count_o),
    .full   (full),
    .empty  (empty)
  );

  // Storage needs no reset: stale entries are hidden while the queue is empty
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_instr [wr_ptr[AW-1:0]] <= F_instr_i;
      mem_pc    [wr_ptr[AW-1:0]] <= F_PC_i;
      mem_npc   [wr_ptr[AW-1:0]] <= F_nPC_i;
      mem_commit[wr_ptr[AW-1:0]] <= F_commit_i;
      mem_meta  [wr_ptr[AW-1:0]] <= F_meta_i;
    end
  end

  always_comb begin
    FD_instr_o  = INSTR_W'(NOP_INSTR);
    FD_PC_o     = PC_W'(NOP_PC);
    FD_nPC_o    = PC_W'(NOP_NPC);
    FD_commit_o = NOP_COMMIT;
    FD_meta_o   = '0;
    if (!empty) begin
      FD_instr_o  = mem_instr [rd_ptr[AW-1:0]];
      FD_PC_o     = mem_pc    [rd_ptr[AW-1:0]];
      FD_nPC_o    = mem_npc   [rd_ptr[AW-1:0]];
      FD_commit_o = mem_commit[rd_ptr[AW-1:0]];
      FD_meta_o   = mem_meta  [rd_ptr[AW-1:0]];
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Flush does not clear these; only reset does
  always_ff @(posedge clk_i) begin
    if (rst) begin
      fq_full_stall_o <= '0;
      fq_flush_cnt_o  <= '0;
    end else begin
      if (F_valid_i && full && (fq_full_stall_o != '1))
        fq_full_stall_o <= fq_full_stall_o + 32'd1;
      if (flush_i && (fq_flush_cnt_o != '1))
        fq_flush_cnt_o <= fq_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based reference model.
// Perf counter checks are compiled in when FETCH_QUEUE_PERF_EN is defined.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk_i = 1'b0;
  logic rst = 1'b1, flush_i = 1'b0, F_valid_i = 1'b0, decode_allow_in_i = 1'b0;
  logic F_ready_o, fetch_vaild_o, F_commit_i = 1'b0, FD_commit_o;
  logic [31:0] F_instr_i = '0, F_PC_i = '0, F_nPC_i = '0;
  logic [31:0] FD_instr_o, FD_PC_o, FD_nPC_o;
  logic [FQ_META_WIDTH-1:0] F_meta_i = '0, FD_meta_o;
  logic [CW-1:0] fq_count_o;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fq_full_stall_o, fq_flush_cnt_o;
  int m_stall = 0, m_flush = 0;
`endif

  always #5 clk_i = ~clk_i;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst(rst), .flush_i(flush_i),
    .F_valid_i(F_valid_i), .F_ready_o(F_ready_o),
    .F_instr_i(F_instr_i), .F_PC_i(F_PC_i), .F_nPC_i(F_nPC_i),
    .F_commit_i(F_commit_i), .F_meta_i(F_meta_i),
    .decode_allow_in_i(decode_allow_in_i), .fetch_vaild_o(fetch_vaild_o),
    .FD_instr_o(FD_instr_o), .FD_PC_o(FD_PC_o), .FD_nPC_o(FD_nPC_o),
    .FD_commit_o(FD_commit_o), .FD_meta_o(FD_meta_o), .fq_count_o(fq_count_o)
`ifdef FETCH_QUEUE_PERF_EN
    , .fq_full_stall_o(fq_full_stall_o), .fq_flush_cnt_o(fq_flush_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] instr, pc, npc;
    logic        commit;
    logic [FQ_META_WIDTH-1:0] meta;
  } ent_t;

  ent_t q[$];
  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count", fq_count_o, q.size());
    chk("ready", F_ready_o, q.size() < DEPTH);
    chk("valid", fetch_vaild_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("pc",     FD_PC_o,     q[0].pc);
      chk("instr",  FD_instr_o,  q[0].instr);
      chk("npc",    FD_nPC_o,    q[0].npc);
      chk("commit", FD_commit_o, q[0].commit);
      chk("meta",   FD_meta_o,   q[0].meta);
    end else begin
      chk("nop_pc",     FD_PC_o,     NOP_PC);
      chk("nop_instr",  FD_instr_o,  NOP_INSTR);
      chk("nop_npc",    FD_nPC_o,    NOP_NPC);
      chk("nop_commit", FD_commit_o, NOP_COMMIT);
      chk("nop_meta",   FD_meta_o,   0);
    end
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_stall", fq_full_stall_o, m_stall);
    chk("perf_flush", fq_flush_cnt_o,  m_flush);
`endif
  endtask

  // One clock: check the model at negedge, drive, clock, then advance the model
  task automatic step(input logic v, input logic a, input logic f, input logic r,
                      input logic [31:0] pc);
    ent_t e;
    fq_meta_t m;
    int sz;
    @(negedge clk_i);
    check_outputs();
    m.jal = 1'($urandom); m.success_hit = 1'($urandom);
    m.local_predict = 1'($urandom); m.global_predict = 1'($urandom);
    m.global_history = 8'($urandom); m.train_predict = 1'($urandom);
    m.train_valid = 1'($urandom);
    e.instr = $urandom; e.pc = pc; e.npc = pc + 32'd4;
    e.commit = 1'($urandom); e.meta = m;
    F_valid_i = v; decode_allow_in_i = a; flush_i = f; rst = r;
    F_instr_i = e.instr; F_PC_i = e.pc; F_nPC_i = e.npc;
    F_commit_i = e.commit; F_meta_i = e.meta;
    @(posedge clk_i);
    sz = q.size();
`ifdef FETCH_QUEUE_PERF_EN
    if (r) begin m_stall = 0; m_flush = 0; end
    else begin
      if (v && sz == DEPTH) m_stall++;
      if (f) m_flush++;
    end
`endif
    if (r || f) q.delete();
    else begin
      if (a && sz != 0) void'(q.pop_front());
      if (v && sz < DEPTH) q.push_back(e);
    end
  endtask

  initial begin
    logic [31:0] pc;
    // 1: reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("t1_valid", fetch_vaild_o, 0);
    chk("t1_ready", F_ready_o, 1);
    chk("t1_count", fq_count_o, 0);
    chk("t1_instr", FD_instr_o, NOP_INSTR);
    step(0, 0, 0, 0, 0);

    // 2: fill with decode stalled, fifth push refused, then drain in order
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h100 + 32'(i * 4));
    #1;
    chk("t2_count", fq_count_o, 4);
    chk("t2_ready", F_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_pop_pc", FD_PC_o, 32'h100 + 32'(i * 4));
      step(0, 1, 0, 0, 0);
    end
    #1 chk("t2_empty", fetch_vaild_o, 0);

    // 3: streaming push+pop, every entry visible exactly one cycle after push
    for (int i = 0; i < 10; i++) begin
      pc = 32'h200 + 32'(i * 4);
      step(1, 1, 0, 0, pc);
      #1;
      chk("t3_pc", FD_PC_o, pc);
      chk("t3_count", fq_count_o, 1);
    end
    step(0, 1, 0, 0, 0);

    // 4: flush a full queue while fetch offers an entry
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h300 + 32'(i * 4));
    step(1, 0, 1, 0, 32'h3F0);
    #1;
    chk("t4_count", fq_count_o, 0);
    chk("t4_valid", fetch_vaild_o, 0);
    chk("t4_ready", F_ready_o, 1);
    step(1, 0, 0, 0, 32'h400);
    #1;
    chk("t4_next_pc", FD_PC_o, 32'h400);
    chk("t4_next_valid", fetch_vaild_o, 1);

    // 5: full queue, pop while push offered: push refused this cycle, taken next
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h404 + 32'(i * 4));
    step(1, 1, 0, 0, 32'h500);
    #1 chk("t5_count3", fq_count_o, 3);
    step(1, 0, 0, 0, 32'h504);
    #1 chk("t5_count4", fq_count_o, 4);

`ifdef FETCH_QUEUE_PERF_EN
    // 6: three full stalls plus two flush cycles, then reset clears both
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h600 + 32'(i * 4));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h6F0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    #1;
    chk("t6_stall", fq_full_stall_o, 3);
    chk("t6_flush", fq_flush_cnt_o, 2);
    step(0, 0, 0, 1, 0);
    #1;
    chk("t6_stall_rst", fq_full_stall_o, 0);
    chk("t6_flush_rst", fq_flush_cnt_o, 0);
`endif

    // Randomized traffic against the model
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0, pc);
      pc += 32'd4;
    end
    @(negedge clk_i);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
